// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed driver for a 4-digit, 7-segment display.
//
// Each digit owns a slot of DIV clock cycles. The first GUARD cycles of
// every slot keep all anodes dark so the previous digit's segment pattern
// cannot ghost onto the new digit. Four slots make one frame of 4*DIV
// cycles.
//
// New data is accepted at any time through a pending register and is only
// transferred to the display register at the frame commit point. The commit
// point is the last cycle of digit 3's slot. A frame therefore never mixes
// old and new digits.
//
// All display outputs are registered. They reflect the digit index and slot
// counter of the previous cycle, which gives one cycle of latency.
//
// Optional feature: define SEG_SCAN_LZB_EN to enable leading-zero blanking.
// With it, digits 3..1 stay dark while they and every more-significant digit
// are zero with no decimal point. Digit 0 is always shown. Without the macro
// none of the blanking logic is compiled.
//
// load handshake: load is a single-cycle strobe with no back-pressure. Every
// cycle in which load=1 and rst=1 captures value/dp_in into the pending
// register, and the last such capture before a commit point wins. A load in
// the same cycle as the commit is held for the following frame, because the
// commit moves the pending contents from before that cycle.

module seg_scan_mux #(
  parameter int DIV   = 100000,
  parameter int GUARD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        E,
  output logic        F,
  output logic        G,
  output logic        Dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  // The slot counter is sized to hold DIV-1. DIV >= 4, so the width is at least 2.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] SLOT_LAST  = CW'(DIV - 1);
  localparam logic [1:0]    DIGIT_LAST = 2'd3;
  localparam logic [3:0]    AN_OFF     = 4'b1111;

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  logic [CW-1:0] slot_q, slot_d;
  logic [1:0]    idx_q, idx_d;

  logic [15:0]   pend_val_q, pend_val_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic          pend_valid_q, pend_valid_d;

  logic [15:0]   disp_val_q, disp_val_d;
  logic [3:0]    disp_dp_q, disp_dp_d;

  // Registered outputs
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          frame_done_q, frame_done_d;

  // ---------------------------------------------------------------------
  // Internal decode signals
  // ---------------------------------------------------------------------
  logic          slot_wrap;
  logic          commit;
  logic          in_guard;
  logic [3:0]    cur_nib;
  logic [3:0]    blank_mask;

  // Segment decode. The pattern bit order is A..G = bits 6..0.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b1111110;
      4'h1:    pat = 7'b0110000;
      4'h2:    pat = 7'b1101101;
      4'h3:    pat = 7'b1111001;
      4'h4:    pat = 7'b0110011;
      4'h5:    pat = 7'b1011011;
      4'h6:    pat = 7'b1011111;
      4'h7:    pat = 7'b1110000;
      4'h8:    pat = 7'b1111111;
      4'h9:    pat = 7'b1110011;
      4'hA:    pat = 7'b1110111;
      4'hB:    pat = 7'b0011111;
      4'hC:    pat = 7'b1001110;
      4'hD:    pat = 7'b0111101;
      4'hE:    pat = 7'b1001111;
      default: pat = 7'b1000111;
    endcase
    return pat;
  endfunction

  // Guard interval detection. With GUARD=0 there is no blanking interval at
  // all, so the comparison is not built.
  generate
    if (GUARD > 0) begin : g_guard
      localparam logic [CW-1:0] GUARD_END = CW'(GUARD);
      // The anodes stay dark while the slot counter is still inside the guard window.
      always_comb begin
        in_guard = (slot_q < GUARD_END);
      end
    end else begin : g_no_guard
      // There is no guard window, so the anodes are never forced dark.
      always_comb begin
        in_guard = 1'b0;
      end
    end
  endgenerate

`ifdef SEG_SCAN_LZB_EN
  // Leading-zero blanking: a digit is blanked when it and every digit above
  // it are zero and carry no decimal point. This is built top-down so that
  // a blank digit k requires digit k+1 to be blank too.
  always_comb begin
    blank_mask    = 4'b0000;
    blank_mask[3] = (disp_val_q[15:12] == 4'h0) && !disp_dp_q[3];
    blank_mask[2] = blank_mask[3] && (disp_val_q[11:8] == 4'h0) && !disp_dp_q[2];
    blank_mask[1] = blank_mask[2] && (disp_val_q[7:4] == 4'h0) && !disp_dp_q[1];
  end
`else
  // Blanking is not compiled in, so every digit is always driven.
  always_comb begin
    blank_mask = 4'b0000;
  end
`endif

  // Scan timing: slot counter, digit index and frame commit point.
  always_comb begin
    slot_wrap = (slot_q == SLOT_LAST);
    commit    = slot_wrap && (idx_q == DIGIT_LAST);
    slot_d    = slot_wrap ? '0 : slot_q + 1'b1;
    idx_d     = slot_wrap ? idx_q + 2'd1 : idx_q;
  end

  // Pending and display registers. The commit uses the pending contents from
  // before this cycle, and a simultaneous load refills pending for the next frame.
  always_comb begin
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;

    if (commit && pend_valid_q) begin
      disp_val_d   = pend_val_q;
      disp_dp_d    = pend_dp_q;
      pend_valid_d = 1'b0;
    end

    if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end
  end

  // Output pattern for the digit currently being scanned.
  always_comb begin
    cur_nib      = disp_val_q[{idx_q, 2'b00} +: 4];
    seg_d        = seg_decode(cur_nib);
    dp_d         = disp_dp_q[idx_q];
    frame_done_d = commit;

    if (in_guard || blank_mask[idx_q]) begin
      an_d = AN_OFF;
    end else begin
      an_d = ~(4'b0001 << idx_q);
    end
  end

  // All state updates, with synchronous active-low reset. Reset also blocks load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_q       <= '0;
      idx_q        <= 2'd0;
      pend_val_q   <= 16'h0000;
      pend_dp_q    <= 4'b0000;
      pend_valid_q <= 1'b0;
      disp_val_q   <= 16'h0000;
      disp_dp_q    <= 4'b0000;
      seg_q        <= 7'b0000000;
      dp_q         <= 1'b0;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Drive the ports from the output registers.
  always_comb begin
    {A, B, C, D, E, F, G} = seg_q;
    Dp                    = dp_q;
    an                    = an_q;
    frame_done            = frame_done_q;
  end

endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 Parameter DIV, default 100000: clock cycles per digit slot, legal range 4..2^20.
REQ-002 Parameter GUARD, default 16: cycles at slot start with all anodes off (anti-ghosting), legal range 0..DIV-2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low.
REQ-005 value  input  16  four hex nibbles; digit k = value[4k+3:4k], digit 0 rightmost.
REQ-006 dp_in  input  4  decimal point request per digit, bit k = digit k.
REQ-007 load  input  1  single-cycle strobe; captures value and dp_in.
REQ-008 A, B, C, D, E, F, G  output  1 each  segment drives, active-high, A..G = pattern bits 6..0.
REQ-009 Dp  output  1  decimal point for the active digit, active-high.
REQ-010 an  output  4  digit anodes, active-low, one-hot-low or all-high.
REQ-011 frame_done  output  1  one-cycle pulse at each frame commit point.

Function
REQ-012 Slot counter SHALL count 0..DIV-1 and wrap to 0; digit index (2 bits) SHALL increment on the wrap, 3 wraps to 0.
REQ-013 Commit point = slot counter at DIV-1 while digit index is 3; frame period SHALL be 4*DIV cycles.
REQ-014 load SHALL copy value/dp_in into a pending register and set pending_valid; a later load before commit SHALL overwrite pending (last load wins).
REQ-015 At commit, if pending_valid, pending SHALL move to the display register and pending_valid SHALL clear; display register SHALL change only at commit (no tearing within a frame).
REQ-016 load coinciding with commit: the pending contents from before that cycle SHALL commit; the new load SHALL be captured into pending and commit at the next frame.
REQ-017 frame_done SHALL pulse at every commit point, whether or not pending_valid was set.
REQ-018 Nibble decode 0..F SHALL be: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1110011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-019 A..G, Dp, an SHALL be registered, reflecting digit index and slot counter of the previous cycle (1-cycle latency).
REQ-020 While slot counter < GUARD, an SHALL be 4'b1111; otherwise an[index] SHALL be 0, all other bits 1.
REQ-021 Segments and Dp SHALL show the indexed display digit for the full slot, including the guard interval.
REQ-022 Load-to-visible latency SHALL be at most 4*DIV+1 cycles.

Reset
REQ-023 While rst=0 at a clock edge: slot counter 0, index 0, display and pending registers 0, pending_valid 0.
REQ-024 Reset outputs: A..G = 0000000, Dp=0, an=4'b1111, frame_done=0.
REQ-025 Reset mid-frame SHALL discard pending data; the first cycle after release SHALL start slot 0 of digit 0 with counter 0.
REQ-026 load asserted while rst=0 SHALL be ignored.

Configuration
REQ-027 Macro SEG_SCAN_LZB_EN defined: leading-zero blanking — digit k (k=3..1) SHALL keep an[k]=1 when display nibbles k..3 are all zero and dp bits k..3 are all zero; digit 0 always shown.
REQ-028 SEG_SCAN_LZB_EN undefined: all four digits SHALL always be driven per REQ-020; no blanking logic compiled.

Verification (DIV=8, GUARD=2)
REQ-029 Reset release, no load -> an cycles 1111,1111,1110 x6, then 1111 x2, 1101..., segments 1111110 for all digits; frame_done every 32 cycles.
REQ-030 load value=16'h1234, dp_in=4'b0001 mid-frame -> digits unchanged until commit; next frame shows 4 (0110011)/digit0 Dp=1, 3,2,1 on digits 1..3.
REQ-031 Two loads 16'hAAAA then 16'hBEEF in same frame -> only BEEF ever displayed; A pattern never appears.
REQ-032 load 16'hCAFE on the commit cycle -> previous pending commits now; CAFE appears one frame later.
REQ-033 rst pulsed low mid-slot with pending 16'h5555 -> outputs per REQ-024, pending discarded, display shows 0000.
REQ-034 With SEG_SCAN_LZB_EN, load 16'h0007, dp_in=0 -> an[3:1] stay 1, digit 0 shows 1110000; without macro all four digits driven.
